sg_write_sequencer: RTL and testbench

Programmable write sequencer and arbiter in front of signal_generator's register-write port (write_strobe / 3-bit address / 5-bit data).
- Holds a small program of register writes, each with a hold duration.
- Replays the program autonomously, optionally looping, so tones and envelopes run without host traffic.
- Merges host "direct" writes onto the same port, with priority over the sequencer.

---
 rtl/sg_seq_pkg.sv | 29 ++
 rtl/sg_write_sequencer_if.sv | 49 ++++
 rtl/sg_seq_prescaler.sv | 34 +++
 rtl/sg_write_sequencer.sv | 168 ++++++++++++++++
 tb/tb_sg_write_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sg_seq_pkg.sv
// ============================================================================
// Module  : sg_seq_pkg
// Brief   : Shared types and constants for the signal_generator write sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package sg_seq_pkg;

   localparam int SG_ADDR_W = 3;
   localparam int SG_DATA_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_NEXT  = 2'd3
   } sg_state_t;

   // Register-write half of a program entry; the top module appends its
   // DUR_W-wide hold duration to form the full step entry.
   typedef struct packed {
      logic [SG_ADDR_W-1:0] addr;
      logic [SG_DATA_W-1:0] data;
   } sg_wr_t;

endpackage

`default_nettype wire

// File: rtl/sg_write_sequencer_if.sv
// ============================================================================
// Module  : sg_write_sequencer_if
// Brief   : Host program/control bus plus the signal_generator write port.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface sg_write_sequencer_if #(
   parameter int STEPS = 8,
   parameter int DUR_W = 8
) ();
   import sg_seq_pkg::*;

   localparam int IDX_W = $clog2(STEPS);

   logic                 prog_we;
   logic [IDX_W-1:0]     prog_idx;
   logic [SG_ADDR_W-1:0] prog_addr;
   logic [SG_DATA_W-1:0] prog_data;
   logic [DUR_W-1:0]     prog_dur;
   logic [IDX_W-1:0]     last_idx;
   logic                 start;
   logic                 stop;
   logic                 loop_en;
   logic                 direct_wr;
   logic [SG_ADDR_W-1:0] direct_addr;
   logic [SG_DATA_W-1:0] direct_data;
   logic                 sg_write_strobe;
   logic [SG_ADDR_W-1:0] sg_address;
   logic [SG_DATA_W-1:0] sg_data;
   logic                 busy;
   logic [IDX_W-1:0]     step_idx;
   logic                 done;

   modport master (
      output prog_we, prog_idx, prog_addr, prog_data, prog_dur, last_idx,
             start, stop, loop_en, direct_wr, direct_addr, direct_data,
      input  sg_write_strobe, sg_address, sg_data, busy, step_idx, done
   );

   modport slave (
      input  prog_we, prog_idx, prog_addr, prog_data, prog_dur, last_idx,
             start, stop, loop_en, direct_wr, direct_addr, direct_data,
      output sg_write_strobe, sg_address, sg_data, busy, step_idx, done
   );

endinterface

`default_nettype wire

// File: rtl/sg_seq_prescaler.sv
// ============================================================================
// Module  : sg_seq_prescaler
// Brief   : Divide-by-PRESCALE tick generator with synchronous clear.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sg_seq_prescaler #(
   parameter int PRESCALE = 256
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic i_clear,
   output logic      o_tick
);

   localparam int              CNT_W  = $clog2(PRESCALE);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clear || (r_cnt == C_LAST)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = (r_cnt == C_LAST) && !i_clear;

endmodule

`default_nettype wire

// File: rtl/sg_write_sequencer.sv
// ============================================================================
// Module  : sg_write_sequencer
// Brief   : Programmable register-write sequencer with host-write priority.
//           SG_SEQ_EXT_TICK_EN: WAIT counts ext_tick pulses instead of prescaler.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sg_write_sequencer
   import sg_seq_pkg::*;
#(
   parameter int STEPS    = 8,
   parameter int DUR_W    = 8,
   parameter int PRESCALE = 256
) (
   input  wire logic           clk,
   input  wire logic           rst,
   sg_write_sequencer_if.slave bus
`ifdef SG_SEQ_EXT_TICK_EN
   ,
   input  wire logic           ext_tick
`endif
);

   localparam int IDX_W = $clog2(STEPS);

   typedef struct packed {
      sg_wr_t           wr;
      logic [DUR_W-1:0] dur;
   } step_t;

   step_t                r_mem [STEPS];
   sg_state_t            r_state,  w_state_n;
   logic [IDX_W-1:0]     r_step,   w_step_n;
   step_t                r_cur,    w_cur_n;
   logic [DUR_W-1:0]     r_ticks,  w_ticks_n;
   logic                 r_strobe, w_strobe_n;
   logic [SG_ADDR_W-1:0] r_addr,   w_addr_n;
   logic [SG_DATA_W-1:0] r_data,   w_data_n;
   logic                 r_busy,   w_busy_n;
   logic                 r_done,   w_done_n;
   logic                 w_tick;
   logic                 w_advance;
   logic                 w_seq_go;
   logic [DUR_W-1:0]     w_dur_m1;

   always_ff @(posedge clk) begin
      if (bus.prog_we) begin
         r_mem[bus.prog_idx] <= '{wr: '{addr: bus.prog_addr, data: bus.prog_data},
                                  dur: bus.prog_dur};
      end
   end

`ifdef SG_SEQ_EXT_TICK_EN
   assign w_tick = ext_tick;
`else
   sg_seq_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk     (clk),
      .rst     (rst),
      .i_clear (r_state == ST_ISSUE),
      .o_tick  (w_tick)
   );
`endif

   assign w_dur_m1 = r_cur.dur - 1'b1;

   // w_seq_go: the sequencer wants the bus at this edge for entry w_step_n.
   // A colliding host write parks it in ST_NEXT with the entry already latched.
   always_comb begin
      w_state_n = r_state;
      w_step_n  = r_step;
      w_cur_n   = r_cur;
      w_ticks_n = r_ticks;
      w_advance = 1'b0;
      w_seq_go  = 1'b0;
      w_done_n  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_step_n = '0;
               w_seq_go = 1'b1;
            end
         end
         ST_ISSUE: begin
            w_ticks_n = '0;
            if (r_cur.dur == '0) w_advance = 1'b1;
            else                 w_state_n = ST_WAIT;
         end
         ST_WAIT: begin
            if (w_tick) begin
               w_ticks_n = r_ticks + 1'b1;
               w_advance = (r_ticks == w_dur_m1);
            end
         end
         ST_NEXT:  w_seq_go  = 1'b1;
         default:  w_state_n = ST_IDLE;
      endcase
      if (w_advance) begin
         if (r_step != bus.last_idx) begin
            w_step_n = r_step + 1'b1;
            w_seq_go = 1'b1;
         end else if (bus.loop_en) begin
            w_step_n = '0;
            w_seq_go = 1'b1;
         end else begin
            w_done_n  = 1'b1;
            w_state_n = ST_IDLE;
         end
      end
      if (bus.stop) begin
         w_state_n = ST_IDLE;
         w_step_n  = r_step;
         w_seq_go  = 1'b0;
         w_done_n  = 1'b0;
      end
      if (w_seq_go) begin
         if (r_state != ST_NEXT) w_cur_n = r_mem[w_step_n];
         w_state_n = bus.direct_wr ? ST_NEXT : ST_ISSUE;
      end
      w_strobe_n = bus.direct_wr || w_seq_go;
      w_addr_n   = r_addr;
      w_data_n   = r_data;
      if (bus.direct_wr) begin
         w_addr_n = bus.direct_addr;
         w_data_n = bus.direct_data;
      end else if (w_seq_go) begin
         w_addr_n = w_cur_n.wr.addr;
         w_data_n = w_cur_n.wr.data;
      end
      w_busy_n = (w_state_n != ST_IDLE) || w_done_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_step   <= '0;
         r_cur    <= '0;
         r_ticks  <= '0;
         r_strobe <= 1'b0;
         r_addr   <= '0;
         r_data   <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_step   <= w_step_n;
         r_cur    <= w_cur_n;
         r_ticks  <= w_ticks_n;
         r_strobe <= w_strobe_n;
         r_addr   <= w_addr_n;
         r_data   <= w_data_n;
         r_busy   <= w_busy_n;
         r_done   <= w_done_n;
      end
   end

   assign bus.sg_write_strobe = r_strobe;
   assign bus.sg_address      = r_addr;
   assign bus.sg_data         = r_data;
   assign bus.busy            = r_busy;
   assign bus.step_idx        = r_step;
   assign bus.done            = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sg_write_sequencer.sv
// ============================================================================
// Module  : tb_sg_write_sequencer
// Brief   : Directed bench with a cycle-schedule model of the write sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sg_write_sequencer;

   localparam int PRESC = 4;

   logic clk;
   logic rst;

   sg_write_sequencer_if #(.STEPS(8), .DUR_W(8)) bus ();

`ifdef SG_SEQ_EXT_TICK_EN
   logic ext_tick;
   initial ext_tick = 1'b0;
`endif

   sg_write_sequencer #(
      .STEPS    (8),
      .DUR_W    (8),
      .PRESCALE (PRESC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus)
`ifdef SG_SEQ_EXT_TICK_EN
      ,
      .ext_tick (ext_tick)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int base  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0d want %0d", nm, cyc - base, act, exp);
      end
   endtask

   // Model: tracks when the next sequencer write is due, in absolute cycles.
   logic [2:0] sh_addr [8];
   logic [4:0] sh_data [8];
   int         sh_dur  [8];
   bit         m_valid = 0;
   bit         m_run   = 0;
   bit         m_pend  = 0;
   int         m_dec   = 0;
   logic [2:0] m_step  = '0;
   bit         seq_fire;
   logic       e_strobe, e_busy, e_done;
   logic [2:0] e_addr;
   logic [4:0] e_data;

   always @(posedge clk) begin
      seq_fire = 1'b0;
      e_done   = 1'b0;
      if (rst) begin
         m_run = 0; m_pend = 0; m_step = '0;
         e_strobe = 0; e_addr = '0; e_data = '0; e_busy = 0;
      end else begin
         if (m_run && bus.stop) begin
            m_run = 0; m_pend = 0;
         end else if (m_run) begin
            if (!m_pend && cyc == m_dec) begin
               if (m_step != bus.last_idx) begin m_step = m_step + 3'd1; m_pend = 1; end
               else if (bus.loop_en)       begin m_step = '0;            m_pend = 1; end
               else                        begin m_run = 0; e_done = 1'b1; end
            end
         end else if (bus.start && !bus.stop) begin
            m_run = 1; m_step = '0; m_pend = 1;
         end
         if (m_pend && !bus.direct_wr) begin
            seq_fire = 1'b1;
            m_pend   = 0;
            m_dec    = cyc + 1 + sh_dur[m_step] * PRESC;
         end
         e_strobe = bus.direct_wr || seq_fire;
         if (bus.direct_wr) begin
            e_addr = bus.direct_addr; e_data = bus.direct_data;
         end else if (seq_fire) begin
            e_addr = sh_addr[m_step]; e_data = sh_data[m_step];
         end
         e_busy = m_run || e_done;
      end
      if (bus.prog_we) begin
         sh_addr[bus.prog_idx] = bus.prog_addr;
         sh_data[bus.prog_idx] = bus.prog_data;
         sh_dur[bus.prog_idx]  = int'(bus.prog_dur);
      end
      cyc++;
      m_valid = 1;
   end

   logic       obs_strb [64];
   logic       obs_busy [64];
   logic [2:0] obs_addr [64];
   logic [4:0] obs_data [64];
   logic [2:0] obs_step [64];
   int         q_strb[$];
   int         q_done[$];

   always @(negedge clk) begin
      int rel;
      if (m_valid) begin
         chk("strobe",   bus.sg_write_strobe, e_strobe);
         chk("address",  bus.sg_address,      e_addr);
         chk("data",     bus.sg_data,         e_data);
         chk("busy",     bus.busy,            e_busy);
         chk("done",     bus.done,            e_done);
         chk("step_idx", bus.step_idx,        m_step);
         rel = cyc - base;
         if (rel >= 0 && rel < 64) begin
            obs_strb[rel] = bus.sg_write_strobe;
            obs_busy[rel] = bus.busy;
            obs_addr[rel] = bus.sg_address;
            obs_data[rel] = bus.sg_data;
            obs_step[rel] = bus.step_idx;
         end
         if (bus.sg_write_strobe === 1'b1) q_strb.push_back(rel);
         if (bus.done === 1'b1)            q_done.push_back(rel);
      end
   end

   task automatic go(input int k);
      while (cyc - base < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle_inputs();
      bus.prog_we = 0; bus.prog_idx = '0; bus.prog_addr = '0; bus.prog_data = '0;
      bus.prog_dur = '0; bus.last_idx = 3'd2; bus.start = 0; bus.stop = 0;
      bus.loop_en = 0; bus.direct_wr = 0; bus.direct_addr = '0; bus.direct_data = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      rst  = 1'b0;
      base = cyc;
      q_strb.delete();
      q_done.delete();
      for (int i = 0; i < 64; i++) begin
         obs_strb[i] = 0; obs_busy[i] = 0; obs_addr[i] = '0; obs_data[i] = '0; obs_step[i] = '0;
      end
   endtask

   task automatic write_entry(input int idx, input int a, input int d, input int dur);
      bus.prog_we = 1; bus.prog_idx = 3'(idx); bus.prog_addr = 3'(a);
      bus.prog_data = 5'(d); bus.prog_dur = 8'(dur);
      @(posedge clk); #1;
      bus.prog_we = 0;
   endtask

   task automatic program_default();
      write_entry(0, 1, 5, 2);
      write_entry(1, 2, 9, 0);
      write_entry(2, 3, 17, 1);
   endtask

   task automatic pulse_start(input int k);
      go(k); bus.start = 1; go(k + 1); bus.start = 0;
   endtask

   task automatic pulse_stop(input int k);
      go(k); bus.stop = 1; go(k + 1); bus.stop = 0;
   endtask

   task automatic chk_strobes(input string nm, input int n, input int e0, input int e1,
                              input int e2, input int e3, input int e4, input int e5);
      int ev[6];
      ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3; ev[4] = e4; ev[5] = e5;
      chk({nm, " strobe count"}, q_strb.size(), n);
      for (int i = 0; i < n && i < 6; i++) begin
         if (i < q_strb.size()) chk({nm, " strobe cycle"}, q_strb[i], ev[i]);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();

      // 1. basic non-looping run
      do_reset(); program_default();
      pulse_start(10); go(40);
      chk_strobes("basic", 3, 11, 20, 21, 0, 0, 0);
      chk("basic done count", q_done.size(), 1);
      if (q_done.size() > 0) chk("basic done cycle", q_done[0], 26);
      chk("basic busy@26", obs_busy[26], 1);
      chk("basic busy@27", obs_busy[27], 0);
      chk("basic addr@11", obs_addr[11], 1);
      chk("basic data@11", obs_data[11], 5);
      chk("basic data@21", obs_data[21], 17);
      chk("basic step@21", obs_step[21], 2);

      // 2. looping run aborted by stop
      do_reset(); program_default();
      bus.loop_en = 1;
      pulse_start(10); pulse_stop(30); go(50);
      chk_strobes("loop", 4, 11, 20, 21, 26, 0, 0);
      chk("loop done count", q_done.size(), 0);
      chk("loop busy@30", obs_busy[30], 1);
      chk("loop busy@31", obs_busy[31], 0);

      // 3. host write collides with step-1 issue
      do_reset(); program_default();
      pulse_start(10);
      go(19); bus.direct_wr = 1; bus.direct_addr = 3'd7; bus.direct_data = 5'd3;
      go(20); bus.direct_wr = 0;
      go(40);
      chk_strobes("collide", 4, 11, 20, 21, 22, 0, 0);
      chk("collide addr@20", obs_addr[20], 7);
      chk("collide data@20", obs_data[20], 3);
      chk("collide addr@21", obs_addr[21], 2);
      if (q_done.size() > 0) chk("collide done cycle", q_done[0], 27);

      // 4a. start together with stop
      do_reset(); program_default();
      go(10); bus.start = 1; bus.stop = 1; go(11); bus.start = 0; bus.stop = 0;
      go(30);
      chk_strobes("start+stop", 0, 0, 0, 0, 0, 0, 0);
      chk("start+stop busy@11", obs_busy[11], 0);

      // 4b. start while busy is ignored
      do_reset(); program_default();
      pulse_start(10); pulse_start(15); go(40);
      chk_strobes("rebusy", 3, 11, 20, 21, 0, 0, 0);
      if (q_done.size() > 0) chk("rebusy done cycle", q_done[0], 26);

      // 5. rewrite step 1 during its own issue cycle
      do_reset(); program_default();
      bus.loop_en = 1;
      pulse_start(10);
      go(20); write_entry(1, 4, 30, 0);
      pulse_stop(37); go(50);
      chk_strobes("rbw", 6, 11, 20, 21, 26, 35, 36);
      chk("rbw data@20", obs_data[20], 9);
      chk("rbw data@35", obs_data[35], 30);
      chk("rbw addr@35", obs_addr[35], 4);

      // 6. reset in the middle of a WAIT
      do_reset(); program_default();
      pulse_start(10);
      go(14); rst = 1'b1; go(15); rst = 1'b0;
      pulse_start(20); go(45);
      chk("midrst busy@14", obs_busy[14], 1);
      chk("midrst busy@15", obs_busy[15], 0);
      chk("midrst addr@15", obs_addr[15], 0);
      chk("midrst data@15", obs_data[15], 0);
      chk("midrst strobe@15", obs_strb[15], 0);
      chk_strobes("midrst", 4, 11, 21, 30, 31, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
